// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// address split, block width and FSM state encoding.
package cache_pkg;

  localparam int ADDR_BITS       = 8;
  localparam int BYTE_BITS       = 8;
  localparam int BLOCK_BITS      = 32;
  localparam int DEF_INDEX_BITS  = 3;
  localparam int DEF_OFFSET_BITS = 2;
  localparam int DEF_TAG_BITS    = ADDR_BITS - DEF_INDEX_BITS - DEF_OFFSET_BITS;
  localparam int MEM_ADDR_BITS   = ADDR_BITS - DEF_OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } cache_state_t;

endpackage

// File: rtl/cache_line_array.sv
// Per-line valid/dirty/tag/data storage with hit compare and byte select.
// Valid and dirty clear asynchronously; tag and data storage is never reset.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = DEF_TAG_BITS
) (
  input  logic                  clk_sys,
  input  logic                  rst_b,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [TAG_BITS-1:0]   tag,
  input  logic [1:0]            offset,
  input  logic                  byte_we,
  input  logic [BYTE_BITS-1:0]  byte_wdata,
  input  logic                  fill_we,
  input  logic [BLOCK_BITS-1:0] fill_data,
  output logic                  hit,
  output logic                  line_dirty,
  output logic [TAG_BITS-1:0]   line_tag,
  output logic [BLOCK_BITS-1:0] line_data,
  output logic [BYTE_BITS-1:0]  rd_byte
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid;
  logic [LINES-1:0]      dirty;
  logic [TAG_BITS-1:0]   tags [LINES];
  logic [BLOCK_BITS-1:0] data [LINES];
  logic [4:0]            bit_sel;

  assign bit_sel = {offset, 3'b000};

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_we) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (byte_we) begin
      dirty[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (fill_we) begin
      tags[index] <= tag;
      data[index] <= fill_data;
    end else if (byte_we) begin
      data[index][bit_sel +: BYTE_BITS] <= byte_wdata;
    end
  end

  assign line_tag   = tags[index];
  assign line_data  = data[index];
  assign line_dirty = dirty[index];
  assign hit        = valid[index] && (tags[index] == tag);
  // Gated by hit so uninitialised data never reaches the CPU bus.
  assign rd_byte    = hit ? line_data[bit_sel +: BYTE_BITS] : '0;

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU byte
// bus and a 32-bit block memory port.
//
//   state     | meaning
//   IDLE      | serve hits; a miss stalls and picks WRITEBACK or FETCH
//   WRITEBACK | dirty victim block written to memory
//   FETCH     | requested block read from memory
//   UPDATE    | fetched block installed; access replays as a hit in IDLE
module data_cache
  import cache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     READ,
  input  logic                     WRITE,
  input  logic [ADDR_BITS-1:0]     ADDRESS,
  input  logic [BYTE_BITS-1:0]     WRITEDATA,
  output logic [BYTE_BITS-1:0]     READDATA,
  output logic                     BUSYWAIT,
  output logic                     MEM_READ,
  output logic                     MEM_WRITE,
  output logic [MEM_ADDR_BITS-1:0] MEM_ADDRESS,
  output logic [BLOCK_BITS-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_BITS-1:0]    MEM_READDATA,
  input  logic                     MEM_BUSYWAIT
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - OFFSET_BITS;

  cache_state_t          state;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] index;
  logic                  request;
  logic                  hit;
  logic                  line_dirty;
  logic [TAG_BITS-1:0]   line_tag;
  logic [BLOCK_BITS-1:0] line_data;
  logic                  byte_we;
  logic                  fill_we;
  logic                  stall;

  assign req_tag = ADDRESS[ADDR_BITS-1 -: TAG_BITS];
  assign index   = ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign request = READ | WRITE;
  // READ and WRITE together resolve as a write.
  assign byte_we = (state == IDLE) && WRITE && hit;
  assign fill_we = (state == UPDATE);

  cache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_lines (
    .clk_sys    (CLK),
    .rst_b      (RESET),
    .index      (index),
    .tag        (req_tag),
    .offset     (ADDRESS[OFFSET_BITS-1:0]),
    .byte_we    (byte_we),
    .byte_wdata (WRITEDATA),
    .fill_we    (fill_we),
    .fill_data  (MEM_READDATA),
    .hit        (hit),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_data  (line_data),
    .rd_byte    (READDATA)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:      if (request && !hit) state <= line_dirty ? WRITEBACK : FETCH;
        WRITEBACK: if (!MEM_BUSYWAIT) state <= FETCH;
        FETCH:     if (!MEM_BUSYWAIT) state <= UPDATE;
        UPDATE:    state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign stall = (state == IDLE) ? (request && !hit) : 1'b1;
  // While reset is held the CPU request may still be up on a now-cold cache.
  assign BUSYWAIT = RESET && stall;

  assign MEM_READ      = (state == FETCH);
  assign MEM_WRITE     = (state == WRITEBACK);
  assign MEM_WRITEDATA = MEM_WRITE ? line_data : '0;

  always_comb begin
    MEM_ADDRESS = '0;
    if (state == WRITEBACK) MEM_ADDRESS = {line_tag, index};
    else if (state == FETCH) MEM_ADDRESS = {req_tag, index};
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits between the CPU and a block-wide data memory.
- Acts as the responder on the CPU's byte memory protocol (READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT), the same protocol the CPU drives today.
- Acts as the initiator on a 32-bit block-wide memory port; the system top-level inserts it in the CPU-memory path.

Parameters:
- INDEX_BITS, 3, log2 of cache lines (8 lines); tag width = 8 - INDEX_BITS - 2.
- OFFSET_BITS, 2, log2 of bytes per block (4 bytes, fixed; not to be overridden).

Ports:
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU read request, held until BUSYWAIT low.
- WRITE  in  1  CPU write request, held until BUSYWAIT low.
- ADDRESS  in  8  CPU byte address {tag, index, offset}.
- WRITEDATA  in  8  CPU store byte.
- READDATA  out  8  load byte to CPU.
- BUSYWAIT  out  1  stall to CPU.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  6  block address {tag, index}.
- MEM_WRITEDATA  out  32  evicted block, byte 0 in [7:0].
- MEM_READDATA  in  32  fetched block, byte 0 in [7:0].
- MEM_BUSYWAIT  in  1  memory stall; low marks transfer complete.

Behaviour:
- Storage per line: valid, dirty, tag, 32-bit data.
- Reset (async, RESET=0): all valid and dirty bits cleared; state IDLE; BUSYWAIT, MEM_READ and MEM_WRITE = 0; READDATA = 0; MEM_ADDRESS = 0; MEM_WRITEDATA = 0. Data arrays are not cleared. Reset during WRITEBACK or FETCH abandons the transfer immediately.
- hit = valid[index] && tag[index] == ADDRESS tag; request = READ | WRITE.
- READ and WRITE both high is illegal; the cache treats it as WRITE.
- IDLE state:
  - BUSYWAIT = request && !hit, combinational, same cycle.
  - READDATA = selected byte of the indexed line, combinational; meaningful only on a read hit.
  - Read hit: zero stall cycles.
  - Write hit: byte written and dirty set on the rising edge; zero stall cycles. The CPU drops WRITE after that edge.
  - Miss with dirty line: next edge goes to WRITEBACK.
  - Miss with clean or invalid line: next edge goes to FETCH.
- WRITEBACK state:
  - MEM_WRITE = 1; MEM_ADDRESS = {stored tag, index}; MEM_WRITEDATA = line data; BUSYWAIT = 1.
  - Leaves on the first edge where MEM_BUSYWAIT = 0, going to FETCH.
- FETCH state:
  - MEM_READ = 1; MEM_ADDRESS = {ADDRESS tag, index}; BUSYWAIT = 1.
  - On the first edge with MEM_BUSYWAIT = 0, goes to UPDATE.
- UPDATE state (one cycle):
  - BUSYWAIT = 1.
  - On the edge: line data = MEM_READDATA, tag = ADDRESS tag, valid = 1, dirty = 0; go to IDLE.
  - The access then re-evaluates as a hit in IDLE. A read returns data with BUSYWAIT low; a write completes on the following edge.
- Memory strobes are outputs of the state register and decode only; MEM_READ and MEM_WRITE are never high together.
- Miss latency (clean line): 1 (IDLE) + fetch cycles + 1 (UPDATE).
- Write-back adds the memory write cycles on top of that.
- Request change during BUSYWAIT violates protocol; behaviour is undefined and not checked.

Decomposition:
- Shared package (cache_pkg): FSM state encoding IDLE/WRITEBACK/FETCH/UPDATE, tag/index/offset widths derived from the parameters, block width 32.
- One sub-module: cache_line_array, holding the valid/dirty/tag/data storage with async clear of valid/dirty, the hit compare and the byte-select mux.
- The FSM stays in data_cache.

Test Plan:
- Cold read, ADDR=0x05, memory block 1 = 0xDDCCBBAA, 5-cycle memory latency -> BUSYWAIT high for 7 cycles, MEM_ADDRESS=6'h01, then READDATA=0xBB with BUSYWAIT low.
- Read hit, ADDR=0x04 immediately after -> BUSYWAIT stays 0; READDATA=0xAA same cycle; MEM_READ stays 0.
- Write hit, WRITE ADDR=0x06 data 0x55 -> no stall; read of 0x06 returns 0x55; dirty[1]=1.
- Dirty eviction, READ ADDR=0x25 (tag 1, index 1) -> MEM_WRITE with MEM_ADDRESS=6'h01 and MEM_WRITEDATA=0xDD55BBAA, then MEM_READ with MEM_ADDRESS=6'h09, then READDATA=byte 1 of the fetched block.
- Write miss, clean line, WRITE ADDR=0x40 data 0x7E -> FETCH only, no MEM_WRITE; after UPDATE the byte is written; a subsequent read of 0x40 gives 0x7E.
- RESET pulled low mid-FETCH -> MEM_READ and BUSYWAIT drop asynchronously; all lines invalid; the next read of the earlier-hit 0x04 misses.
